// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 clock/data lines, deframes
// 11-bit frames and folds E0/F0 prefixes into complete key events.
module ps2_kbd_rx #(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt, state_eff;
    logic        clk_s1, clk_s2, clk_hist;
    logic        dat_s1, dat_s2;
    logic        fe, timeout;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] idle_cnt, idle_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        parity, parity_nxt;
    logic        ext, ext_nxt, rel, rel_nxt;
    logic        byte_valid_nxt, key_strobe_nxt, frame_err_nxt;
    logic [7:0]  byte_data_nxt, key_code_nxt;
    logic        key_extended_nxt, key_released_nxt;

    assign fe      = clk_hist & ~clk_s2;
    assign timeout = (state != IDLE) && (idle_cnt >= TIMEOUT);

    always_comb begin
        state_nxt        = state;
        state_eff        = state;
        bit_cnt_nxt      = bit_cnt;
        shift_nxt        = shift;
        parity_nxt       = parity;
        ext_nxt          = ext;
        rel_nxt          = rel;
        byte_valid_nxt   = 1'b0;
        key_strobe_nxt   = 1'b0;
        frame_err_nxt    = 1'b0;
        byte_data_nxt    = byte_data;
        key_code_nxt     = key_code;
        key_extended_nxt = key_extended;
        key_released_nxt = key_released;

        // Timeout wins; a coincident edge is then treated as arriving in IDLE.
        if (timeout) begin
            frame_err_nxt = 1'b1;
            ext_nxt       = 1'b0;
            rel_nxt       = 1'b0;
            state_eff     = IDLE;
        end
        state_nxt = state_eff;

        if (fe) begin
            case (state_eff)
                IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    shift_nxt   = {dat_s2, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    parity_nxt = dat_s2;
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s2 && (^{shift, parity})) begin
                        byte_valid_nxt = 1'b1;
                        byte_data_nxt  = shift;
                        if (shift == 8'hE0) begin
                            ext_nxt = 1'b1;
                        end else if (shift == 8'hF0) begin
                            rel_nxt = 1'b1;
                        end else begin
                            key_strobe_nxt   = 1'b1;
                            key_code_nxt     = shift;
                            key_extended_nxt = ext;
                            key_released_nxt = rel;
                            ext_nxt          = 1'b0;
                            rel_nxt          = 1'b0;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                        ext_nxt       = 1'b0;
                        rel_nxt       = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (state_nxt == IDLE || fe) idle_cnt_nxt = 16'd0;
        else                         idle_cnt_nxt = idle_cnt + 16'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1       <= 1'b1;
            clk_s2       <= 1'b1;
            clk_hist     <= 1'b1;
            dat_s1       <= 1'b1;
            dat_s2       <= 1'b1;
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            idle_cnt     <= 16'd0;
            shift        <= 8'h00;
            parity       <= 1'b0;
            ext          <= 1'b0;
            rel          <= 1'b0;
            byte_valid   <= 1'b0;
            key_strobe   <= 1'b0;
            frame_err    <= 1'b0;
            byte_data    <= 8'h00;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_released <= 1'b0;
        end else begin
            clk_s1       <= ps2_kbd_clk;
            clk_s2       <= clk_s1;
            clk_hist     <= clk_s2;
            dat_s1       <= ps2_kbd_data;
            dat_s2       <= dat_s1;
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            idle_cnt     <= idle_cnt_nxt;
            shift        <= shift_nxt;
            parity       <= parity_nxt;
            ext          <= ext_nxt;
            rel          <= rel_nxt;
            byte_valid   <= byte_valid_nxt;
            key_strobe   <= key_strobe_nxt;
            frame_err    <= frame_err_nxt;
            byte_data    <= byte_data_nxt;
            key_code     <= key_code_nxt;
            key_extended <= key_extended_nxt;
            key_released <= key_released_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: table of frames with expected decode results,
// plus hand-written sequences for timeout, mid-frame reset and back-to-back frames.
module tb_ps2_kbd_rx;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       frame_err;

    ps2_kbd_rx dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_released (key_released),
        .frame_err    (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_strobe = 0, n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters and in-order byte scoreboard.
    always @(negedge clk_sys) begin
        if (byte_valid === 1'b1) n_valid++;
        if (key_strobe === 1'b1) n_strobe++;
        if (frame_err === 1'b1)  n_err++;
        if (byte_valid === 1'b1) begin
            check("valid_err_exclusive", {31'd0, frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got byte %0h expected none", byte_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_byte", {24'd0, byte_data}, {24'd0, sb_exp});
            end
        end
    end

    function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
        return {stop, (~^d) ^ flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_kbd_data = bits[i];
            repeat (h) @(negedge clk_sys);
            ps2_kbd_clk = 1'b0;
            repeat (h) @(negedge clk_sys);
            ps2_kbd_clk = 1'b1;
        end
        @(negedge clk_sys);
        ps2_kbd_data = 1'b1;
    endtask

    task automatic check_keys(input string tag, input logic [7:0] code, input logic e, input logic r);
        check({tag, "_key_code"}, {24'd0, key_code}, {24'd0, code});
        check({tag, "_key_ext"}, {31'd0, key_extended}, {31'd0, e});
        check({tag, "_key_rel"}, {31'd0, key_released}, {31'd0, r});
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        int         h;
        int         e_valid;
        int         e_strobe;
        int         e_err;
        logic [7:0] e_byte;
        logic [7:0] e_code;
        logic       e_ext;
        logic       e_rel;
    } vec_t;

    vec_t vecs[18];
    int   v0, s0, e0;
    logic [7:0] b2b[8];

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8, 1, 1, 0, 8'h1C, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hE0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hF0, 8'h1C, 1'b0, 1'b0};
        vecs[3]  = '{8'h75, 1'b0, 1'b1, 8, 1, 1, 0, 8'h75, 8'h75, 1'b1, 1'b1};
        vecs[4]  = '{8'h1C, 1'b1, 1'b1, 8, 0, 0, 1, 8'h75, 8'h75, 1'b1, 1'b1};
        vecs[5]  = '{8'h5A, 1'b0, 1'b0, 8, 0, 0, 1, 8'h75, 8'h75, 1'b1, 1'b1};
        vecs[6]  = '{8'hF0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hF0, 8'h75, 1'b1, 1'b1};
        vecs[7]  = '{8'h1C, 1'b0, 1'b1, 8, 1, 1, 0, 8'h1C, 8'h1C, 1'b0, 1'b1};
        vecs[8]  = '{8'hE0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hE0, 8'h1C, 1'b0, 1'b1};
        vecs[9]  = '{8'hE0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hE0, 8'h1C, 1'b0, 1'b1};
        vecs[10] = '{8'h6B, 1'b0, 1'b1, 8, 1, 1, 0, 8'h6B, 8'h6B, 1'b1, 1'b0};
        vecs[11] = '{8'hF0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hF0, 8'h6B, 1'b1, 1'b0};
        vecs[12] = '{8'hE0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hE0, 8'h6B, 1'b1, 1'b0};
        vecs[13] = '{8'h12, 1'b0, 1'b1, 8, 1, 1, 0, 8'h12, 8'h12, 1'b1, 1'b1};
        vecs[14] = '{8'hE0, 1'b0, 1'b1, 8, 1, 0, 0, 8'hE0, 8'h12, 1'b1, 1'b1};
        vecs[15] = '{8'h33, 1'b1, 1'b1, 8, 0, 0, 1, 8'hE0, 8'h12, 1'b1, 1'b1};
        vecs[16] = '{8'h1C, 1'b0, 1'b1, 4, 1, 1, 0, 8'h1C, 8'h1C, 1'b0, 1'b0};
        vecs[17] = '{8'h4B, 1'b0, 1'b1, 4, 1, 1, 0, 8'h4B, 8'h4B, 1'b0, 1'b0};
        b2b = '{8'h15, 8'h2E, 8'h3C, 8'h4B, 8'h5A, 8'h66, 8'h7D, 8'h83};

        // Reset state.
        reset        = 1'b1;
        ps2_kbd_clk  = 1'b1;
        ps2_kbd_data = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_key_strobe", {31'd0, key_strobe}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_byte_data", {24'd0, byte_data}, 32'd0);
        check_keys("rst", 8'h00, 1'b0, 1'b0);

        // Table of single frames.
        for (int i = 0; i < 18; i++) begin
            v0 = n_valid; s0 = n_strobe; e0 = n_err;
            if (vecs[i].e_valid != 0) exp_q.push_back(vecs[i].data);
            send_bits(frame(vecs[i].data, vecs[i].flip, vecs[i].stop), 11, vecs[i].h);
            repeat (8) @(negedge clk_sys);
            check($sformatf("v%0d_valid_cnt", i), n_valid - v0, vecs[i].e_valid);
            check($sformatf("v%0d_strobe_cnt", i), n_strobe - s0, vecs[i].e_strobe);
            check($sformatf("v%0d_err_cnt", i), n_err - e0, vecs[i].e_err);
            check($sformatf("v%0d_byte_data", i), {24'd0, byte_data}, {24'd0, vecs[i].e_byte});
            check_keys($sformatf("v%0d", i), vecs[i].e_code, vecs[i].e_ext, vecs[i].e_rel);
        end

        // F0, then a frame stalled after 4 data bits until the timeout fires.
        v0 = n_valid; s0 = n_strobe; e0 = n_err;
        exp_q.push_back(8'hF0);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11, 8);
        send_bits(frame(8'hA5, 1'b0, 1'b1), 5, 8);
        repeat (5100) @(negedge clk_sys);
        check("to_err_cnt", n_err - e0, 1);
        check("to_valid_cnt", n_valid - v0, 1);
        exp_q.push_back(8'h16);
        send_bits(frame(8'h16, 1'b0, 1'b1), 11, 8);
        repeat (8) @(negedge clk_sys);
        check("to_after_strobe_cnt", n_strobe - s0, 1);
        check("to_after_err_cnt", n_err - e0, 1);
        check_keys("to_after", 8'h16, 1'b0, 1'b0);

        // Reset during data bit 5.
        v0 = n_valid; s0 = n_strobe; e0 = n_err;
        send_bits(frame(8'hA5, 1'b0, 1'b1), 6, 8);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("mr_pulses", (n_valid - v0) + (n_strobe - s0) + (n_err - e0), 0);
        check("mr_byte_data", {24'd0, byte_data}, 32'd0);
        check_keys("mr", 8'h00, 1'b0, 1'b0);
        exp_q.push_back(8'h29);
        send_bits(frame(8'h29, 1'b0, 1'b1), 11, 8);
        repeat (8) @(negedge clk_sys);
        check("mr_after_strobe_cnt", n_strobe - s0, 1);
        check_keys("mr_after", 8'h29, 1'b0, 1'b0);

        // Eight back-to-back frames at a slow PS/2 clock.
        v0 = n_valid; s0 = n_strobe; e0 = n_err;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b2b[i]);
            send_bits(frame(b2b[i], 1'b0, 1'b1), 11, 100);
        end
        repeat (20) @(negedge clk_sys);
        check("b2b_valid_cnt", n_valid - v0, 8);
        check("b2b_strobe_cnt", n_strobe - s0, 8);
        check("b2b_err_cnt", n_err - e0, 0);
        check_keys("b2b", 8'h83, 1'b0, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd5000: clk_sys cycles allowed between falling edges inside a frame.
REQ-002 SHALL have port clk_sys, input, 1: the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ps2_kbd_clk, input, 1: PS/2 clock from the mist_io keyboard emulation, idle high.
REQ-005 SHALL have port ps2_kbd_data, input, 1: PS/2 data, idle high.
REQ-006 SHALL have port byte_valid, output, 1: one-cycle pulse, any good frame received.
REQ-007 SHALL have port byte_data, output, 8: raw byte of the last good frame.
REQ-008 SHALL have port key_strobe, output, 1: one-cycle pulse, complete key event.
REQ-009 SHALL have port key_code, output, 8: scancode of the event.
REQ-010 SHALL have port key_extended, output, 1: the event was preceded by E0.
REQ-011 SHALL have port key_released, output, 1: the event was preceded by F0.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on parity, stop or timeout error.

Function
REQ-013 SHALL pass ps2_kbd_clk and ps2_kbd_data through 2-FF synchronizers, plus one history register on clock, for falling-edge detection.
REQ-014 SHALL sample data only on a detected synchronized clock falling edge ("fe").
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
- IDLE: fe with data 0 -> DATA, bit counter 0; fe with data 1 -> stay in IDLE, no error.
- DATA: shift data in LSB first; after the 8th bit -> PARITY.
- PARITY: store the bit -> STOP.
- STOP: evaluate the frame -> IDLE.
REQ-016 SHALL accept a frame only when stop bit = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
REQ-017 SHALL, on a good frame, update byte_data and pulse byte_valid in the cycle after the stop-bit fe is detected.
REQ-018 SHALL, on a bad parity or stop bit, pulse frame_err in that same cycle, leave byte_data unchanged, clear the prefix flags, and return to IDLE.
REQ-019 SHALL keep a 16-bit idle counter outside IDLE that clears on each fe.
REQ-020 SHALL, when the idle counter reaches TIMEOUT, pulse frame_err, clear the prefix flags, and force IDLE.
REQ-021 SHALL handle prefixes as follows:
- good byte E0: set ext flag, no key_strobe.
- good byte F0: set rel flag, no key_strobe.
- any other good byte: pulse key_strobe in the same cycle as byte_valid; key_code = byte, key_extended = ext flag, key_released = rel flag; both flags clear.
REQ-022 SHALL accept E0 and F0 in either order and repeated; a flag stays set until consumed or cleared.
REQ-023 SHALL hold key_code, key_extended and key_released stable between strobes.
REQ-024 SHALL never assert byte_valid and frame_err in the same cycle.
REQ-025 SHALL detect an fe in the same cycle as the timeout, apply the timeout first, and evaluate that fe in IDLE.
REQ-026 SHALL tolerate a minimum of 4 clk_sys cycles per PS/2 clock half-period.

Reset
REQ-027 SHALL, on reset, set: FSM to IDLE; bit counter, idle counter and prefix flags to 0; byte_valid, key_strobe and frame_err to 0; byte_data and key_code to 8'h00; key_extended and key_released to 0; synchronizers to 1.
REQ-028 SHALL abandon any partially received frame on reset asserted mid-frame, with no pulse on any output.

Verification
REQ-029 SHALL cover this scenario: frame 8'h1C, odd parity 0, stop 1 -> byte_valid and key_strobe pulse once; key_code 8'h1C, key_extended 0, key_released 0.
REQ-030 SHALL cover this scenario: frames E0, F0, 75 -> two byte_valid pulses with no key_strobe, then key_strobe with key_code 8'h75, key_extended 1, key_released 1; flags 0 afterwards.
REQ-031 SHALL cover this scenario: frame 8'h1C with parity bit 1 -> frame_err pulse; no byte_valid; byte_data keeps its prior value.
REQ-032 SHALL cover this scenario: F0 good, then a frame stopped after 4 data bits for more than TIMEOUT cycles -> frame_err once, FSM IDLE; next frame 8'h16 -> key_released 0.
REQ-033 SHALL cover this scenario: reset pulsed during data bit 5 of a frame -> all outputs at reset values; the following good frame 8'h29 is decoded correctly.
REQ-034 SHALL cover this scenario: 8 back-to-back frames driven by mist_io with PS2DIV=100 -> 8 byte_valid pulses, bytes in order, zero frame_err.
